// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared defaults and sizing helpers for the write-back controller.
package regfile_wb_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_PORTS_DEF = 2;
  localparam int MAX_REGS = 256;
  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction
  function automatic int popcount(input logic [MAX_REGS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_REGS; i++) c = c + int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/regfile_wb_ctrl_onehot_dec.sv
// onehot_dec: index to one-hot decoder, all-zero when disabled.
module onehot_dec
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int NUM_REGS = num_regs(ADDR_W)
) (
  input  logic [ADDR_W-1:0]   idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  assign onehot = en ? NUM_REGS'(1) << idx : '0;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: prioritised write-back wordline decode plus WAW busy scoreboard.
module regfile_wb_ctrl
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ZERO_RO = 1,
  localparam int NUM_REGS = num_regs(ADDR_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_rd,
  output logic                          iss_ready,
  input  logic [NUM_PORTS-1:0]          wb_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wb_rd,
  input  logic                          flush,
  output logic [NUM_PORTS*NUM_REGS-1:0] wordline,
  output logic [NUM_REGS-1:0]           busy,
  output logic [ADDR_W:0]               pending,
  output logic                          wb_conflict
);
  logic [ADDR_W-1:0] rd [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid, drop;
  logic [NUM_PORTS*NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] clr, set, busy_n;
  logic zero_iss;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      assign rd[g] = wb_rd[g*ADDR_W +: ADDR_W];
      onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
        .idx(rd[g]),
        .en(valid[g] && !drop[g]),
        .onehot(dec[g*NUM_REGS +: NUM_REGS])
      );
    end
  endgenerate

  // A port loses to any lower-indexed valid port aimed at the same register.
  always_comb begin
    valid = '0;
    drop = '0;
    clr = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      valid[p] = wb_en[p] && !flush && !(ZERO_RO != 0 && rd[p] == '0);
    for (int p = 0; p < NUM_PORTS; p++)
      for (int q = 0; q < NUM_PORTS; q++)
        if (q < p && valid[p] && valid[q] && rd[q] == rd[p]) drop[p] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) clr = clr | dec[p*NUM_REGS +: NUM_REGS];
  end

  assign zero_iss = ZERO_RO != 0 && iss_rd == '0;
  assign iss_ready = !flush && (!busy[iss_rd] || zero_iss);
  assign set = (iss_valid && iss_ready && !zero_iss) ? NUM_REGS'(1) << iss_rd : '0;
  assign busy_n = flush ? '0 : (busy & ~clr) | set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordline <= '0;
      busy <= '0;
      pending <= '0;
      wb_conflict <= 1'b0;
    end else begin
      wordline <= dec;
      busy <= busy_n;
      pending <= (ADDR_W+1)'(popcount(MAX_REGS'(busy_n)));
      wb_conflict <= |drop;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed checks of decode, priority, scoreboard, flush and reset.
module tb_regfile_wb_ctrl;
  logic clk = 0, rst = 1, iss_valid = 0, flush = 0;
  logic [3:0] iss_rd = 0;
  logic [1:0] wb_en = 0;
  logic [7:0] wb_rd = 0;
  logic iss_ready, wb_conflict, iss_ready0, wb_conflict0;
  logic [31:0] wordline, wordline0;
  logic [15:0] busy, busy0;
  logic [4:0] pending, pending0;
  int pass = 0, total = 0;

  regfile_wb_ctrl #(.ADDR_W(4), .NUM_PORTS(2), .ZERO_RO(1)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush), .wordline(wordline), .busy(busy),
    .pending(pending), .wb_conflict(wb_conflict));

  regfile_wb_ctrl #(.ADDR_W(4), .NUM_PORTS(2), .ZERO_RO(0)) dut0 (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready0),
    .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush), .wordline(wordline0), .busy(busy0),
    .pending(pending0), .wb_conflict(wb_conflict0));

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    tick; tick;
    total++; if (wordline !== 32'h0) $display("FAIL reset_wordline got %h exp %h", wordline, 32'h0); else pass++;
    total++; if (busy !== 16'h0) $display("FAIL reset_busy got %h exp %h", busy, 16'h0); else pass++;
    total++; if (pending !== 5'd0) $display("FAIL reset_pending got %0d exp 0", pending); else pass++;
    total++; if (wb_conflict !== 1'b0) $display("FAIL reset_conflict got %b exp 0", wb_conflict); else pass++;
    total++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b exp 1", iss_ready); else pass++;
    rst = 0;
    tick;
  endtask

  task test_wb_decode;
    wb_en = 2'b01; wb_rd = {4'd0, 4'd5};
    tick;
    wb_en = 0;
    total++; if (wordline !== 32'h0000_0020) $display("FAIL wb_decode got %h exp %h", wordline, 32'h20); else pass++;
    total++; if (wb_conflict !== 1'b0) $display("FAIL wb_decode_conflict got %b exp 0", wb_conflict); else pass++;
    tick;
    total++; if (wordline !== 32'h0) $display("FAIL wb_single_pulse got %h exp %h", wordline, 32'h0); else pass++;
  endtask

  task test_issue;
    iss_valid = 1; iss_rd = 3;
    #1;
    total++; if (iss_ready !== 1'b1) $display("FAIL issue_ready got %b exp 1", iss_ready); else pass++;
    tick;
    total++; if (busy !== 16'h0008) $display("FAIL issue_busy got %h exp %h", busy, 16'h0008); else pass++;
    total++; if (pending !== 5'd1) $display("FAIL issue_pending got %0d exp 1", pending); else pass++;
    total++; if (iss_ready !== 1'b0) $display("FAIL issue_blocked got %b exp 0", iss_ready); else pass++;
    iss_valid = 0; wb_en = 2'b10; wb_rd = {4'd3, 4'd0};
    tick;
    wb_en = 0;
    total++; if (busy !== 16'h0) $display("FAIL wb_clear_busy got %h exp %h", busy, 16'h0); else pass++;
    total++; if (wordline !== 32'h0008_0000) $display("FAIL wb_port1 got %h exp %h", wordline, 32'h0008_0000); else pass++;
    total++; if (iss_ready !== 1'b1) $display("FAIL wb_clear_ready got %b exp 1", iss_ready); else pass++;
  endtask

  task test_conflict;
    wb_en = 2'b11; wb_rd = {4'd7, 4'd7};
    tick;
    wb_en = 0;
    total++; if (wordline !== 32'h0000_0080) $display("FAIL conflict_wordline got %h exp %h", wordline, 32'h80); else pass++;
    total++; if (wb_conflict !== 1'b1) $display("FAIL conflict_pulse got %b exp 1", wb_conflict); else pass++;
    tick;
    total++; if (wb_conflict !== 1'b0) $display("FAIL conflict_end got %b exp 0", wb_conflict); else pass++;
  endtask

  task test_zero;
    iss_valid = 1; iss_rd = 0; wb_en = 2'b01; wb_rd = 8'h00;
    #1;
    total++; if (iss_ready !== 1'b1) $display("FAIL zero_ro_ready got %b exp 1", iss_ready); else pass++;
    total++; if (iss_ready0 !== 1'b1) $display("FAIL zero_rw_ready got %b exp 1", iss_ready0); else pass++;
    tick;
    iss_valid = 0; wb_en = 0;
    total++; if (busy !== 16'h0) $display("FAIL zero_ro_busy got %h exp %h", busy, 16'h0); else pass++;
    total++; if (wordline !== 32'h0) $display("FAIL zero_ro_wordline got %h exp %h", wordline, 32'h0); else pass++;
    total++; if (busy0 !== 16'h0001) $display("FAIL zero_rw_busy got %h exp %h", busy0, 16'h0001); else pass++;
    total++; if (wordline0 !== 32'h1) $display("FAIL zero_rw_wordline got %h exp %h", wordline0, 32'h1); else pass++;
    total++; if (iss_ready0 !== 1'b0) $display("FAIL zero_rw_blocked got %b exp 0", iss_ready0); else pass++;
  endtask

  task test_set_wins;
    iss_valid = 1; iss_rd = 9;
    tick;
    iss_rd = 12;
    tick;
    total++; if (busy !== 16'h1200) $display("FAIL busy_9_12 got %h exp %h", busy, 16'h1200); else pass++;
    iss_rd = 9;
    #1;
    total++; if (iss_ready !== 1'b0) $display("FAIL blocked_9 got %b exp 0", iss_ready); else pass++;
    iss_rd = 4; wb_en = 2'b01; wb_rd = {4'd0, 4'd4};
    #1;
    total++; if (iss_ready !== 1'b1) $display("FAIL ready_4 got %b exp 1", iss_ready); else pass++;
    tick;
    iss_valid = 0;
    total++; if (busy !== 16'h1210) $display("FAIL set_wins got %h exp %h", busy, 16'h1210); else pass++;
    total++; if (pending !== 5'd3) $display("FAIL set_wins_pending got %0d exp 3", pending); else pass++;
    total++; if (wordline !== 32'h0000_0010) $display("FAIL set_wins_wordline got %h exp %h", wordline, 32'h10); else pass++;
  endtask

  task test_back_to_back;
    wb_rd = {4'd0, 4'd9};
    tick;
    total++; if (wordline !== 32'h0000_0200) $display("FAIL b2b_first got %h exp %h", wordline, 32'h200); else pass++;
    total++; if (busy !== 16'h1010) $display("FAIL b2b_busy got %h exp %h", busy, 16'h1010); else pass++;
    tick;
    wb_en = 0;
    total++; if (wordline !== 32'h0000_0200) $display("FAIL b2b_second got %h exp %h", wordline, 32'h200); else pass++;
    total++; if (pending !== 5'd2) $display("FAIL b2b_pending got %0d exp 2", pending); else pass++;
  endtask

  task test_flush;
    iss_valid = 1; iss_rd = 9;
    tick;
    total++; if (pending !== 5'd3) $display("FAIL preflush_pending got %0d exp 3", pending); else pass++;
    flush = 1; wb_en = 2'b11; wb_rd = {4'd5, 4'd6}; iss_rd = 2;
    #1;
    total++; if (iss_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", iss_ready); else pass++;
    tick;
    flush = 0; wb_en = 0; iss_valid = 0;
    total++; if (busy !== 16'h0) $display("FAIL flush_busy got %h exp %h", busy, 16'h0); else pass++;
    total++; if (pending !== 5'd0) $display("FAIL flush_pending got %0d exp 0", pending); else pass++;
    total++; if (wordline !== 32'h0) $display("FAIL flush_wordline got %h exp %h", wordline, 32'h0); else pass++;
    total++; if (wb_conflict !== 1'b0) $display("FAIL flush_conflict got %b exp 0", wb_conflict); else pass++;
    total++; if (busy0 !== 16'h0) $display("FAIL flush_busy0 got %h exp %h", busy0, 16'h0); else pass++;
  endtask

  task test_async_rst;
    iss_valid = 1; iss_rd = 5;
    tick;
    iss_valid = 0; wb_en = 2'b01; wb_rd = {4'd0, 4'd8};
    tick;
    wb_en = 0;
    total++; if (busy !== 16'h0020) $display("FAIL prerst_busy got %h exp %h", busy, 16'h0020); else pass++;
    total++; if (wordline !== 32'h0000_0100) $display("FAIL prerst_wordline got %h exp %h", wordline, 32'h100); else pass++;
    #2 rst = 1;
    #1;
    total++; if (busy !== 16'h0) $display("FAIL async_busy got %h exp %h", busy, 16'h0); else pass++;
    total++; if (wordline !== 32'h0) $display("FAIL async_wordline got %h exp %h", wordline, 32'h0); else pass++;
    total++; if (pending !== 5'd0) $display("FAIL async_pending got %0d exp 0", pending); else pass++;
    tick;
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_wb_decode;
    test_issue;
    test_conflict;
    test_zero;
    test_set_wins;
    test_back_to_back;
    test_flush;
    test_async_rst;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Parametrised register-file write-back controller: decodes up to NUM_PORTS write-back requests into registered one-hot wordlines and tracks a per-register busy scoreboard that stalls issue of instructions targeting a register with an outstanding write (WAW). It sits between decode/issue and the register-file array and replaces the fixed 4-to-16 write decoder. Generalised in register count, port count and register-0 handling.

## Interface
Parameters:
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W
- NUM_PORTS, 2, write-back ports; port 0 has highest priority
- ZERO_RO, 1, when 1 register 0 is read-only: never written, never busy

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  issue request with a destination register
- iss_rd  in  ADDR_W  destination register of issuing instruction
- iss_ready  out  1  issue accepted this cycle (combinational)
- wb_en  in  NUM_PORTS  per-port write-back request
- wb_rd  in  NUM_PORTS*ADDR_W  per-port destination; port p at [p*ADDR_W +: ADDR_W]
- flush  in  1  clear scoreboard, cancel this cycle's write-backs
- wordline  out  NUM_PORTS*NUM_REGS  registered one-hot write enables; port p at [p*NUM_REGS +: NUM_REGS]
- busy  out  NUM_REGS  scoreboard, bit r = pending write to r
- pending  out  ADDR_W+1  population count of busy
- wb_conflict  out  1  registered pulse: a lower-priority port was dropped

## Operation
- Reset: wordline, busy, pending, wb_conflict all 0; iss_ready follows its equation from reset state.
- iss_ready = !flush && (!busy[iss_rd] || (ZERO_RO && iss_rd==0)). Handshake completes when iss_valid && iss_ready; iss_ready does not depend on iss_valid.
- Accepted issue sets busy[iss_rd] next cycle (not for reg 0 when ZERO_RO).
- Write-back decode: port p valid if wb_en[p] && !flush && !(ZERO_RO && wb_rd[p]==0). If a higher-priority valid port targets the same register, port p is dropped and wb_conflict pulses next cycle.
- Each surviving port asserts exactly one wordline bit for one cycle; all others 0.
- Surviving write-back clears busy[wb_rd[p]] next cycle. Write-back to a non-busy register still writes; busy unaffected.
- Same-cycle issue set and write-back clear of the same register: set wins (busy stays 1).
- flush: busy cleared to 0 next cycle, no issue accepted, all wordlines 0 next cycle, wb_conflict 0.
- pending = popcount(busy), registered alongside busy (same cycle consistency required).

## Timing
- wb request cycle t -> wordline bit high cycle t+1 only, busy bit clear visible t+1.
- Issue handshake cycle t -> busy bit high t+1; an issue to same reg at t+1 sees iss_ready=0.
- Back-to-back write-backs to same register on consecutive cycles produce consecutive wordline pulses.
- Async rst mid-operation: all registered outputs 0 immediately, independent of clk.
- No combinational path from wb_en/wb_rd to any output.

## Structure
- Package regfile_wb_pkg: default ADDR_W/NUM_PORTS constants, localparam-style function for NUM_REGS and popcount.
- Sub-module onehot_dec (parameter ADDR_W; inputs idx, en; output NUM_REGS one-hot, all-zero when !en), instantiated once per port.
- Top holds priority/conflict logic, scoreboard register, output registers.

## Test plan
- Reset then wb_en=01, wb_rd[0]=5 -> next cycle wordline[0*16+5]=1 only, port-1 wordline 0, wb_conflict 0.
- Issue rd=3 accepted; next cycle busy=16'h0008, pending=1, issue rd=3 -> iss_ready=0; wb port1 rd=3 -> next cycle busy=0, iss_ready=1.
- Both ports wb_rd=7 same cycle -> only port-0 wordline bit 7 high, wb_conflict=1 for one cycle.
- ZERO_RO=1: issue rd=0 and wb rd=0 -> iss_ready=1, busy stays 0, no wordline; ZERO_RO=0: same stimulus sets/asserts bit 0.
- Busy 9 and 12, same cycle issue rd=9? blocked; issue rd=4 with wb rd=4 simultaneously -> busy[4]=1 afterwards (set wins).
- pending=3, assert flush with wb_en=11 -> next cycle busy=0, pending=0, all wordlines 0; assert rst asynchronously mid-stream -> outputs 0 before next edge.
